kim_id_ex_p: RTL and testbench
==============================

# kim_id_ex_p

ID/EX pipeline register with EX-stage operand forwarding for the 32-bit pipelined MIPS core. It captures decoded operands and control from the decode stage on each clock. It resolves RAW hazards against the MEM and WB stages and drives the ALU's `a`, `b` and `alu_control` inputs directly. It also drives the EX-stage control and store data onward to the EX/MEM register.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `REG_ADDR_WIDTH`, 5, register-file index width
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  hold current contents (hazard unit load-use stall)
- `flush`  in  1  load a bubble (branch taken / exception)
- `id_rd1`, `id_rd2`  in  DATA_WIDTH  register-file read data (rs, rt)
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_rs`, `id_rt`, `id_rd`  in  REG_ADDR_WIDTH  source/destination indices
- `id_alu_control`  in  4  ALU opcode
- `id_alu_src`  in  1  1: b = immediate
- `id_reg_dst`  in  1  1: write reg = rd, 0: rt
- `id_reg_write`, `id_mem_write`, `id_mem_to_reg`, `id_branch`  in  1 each  decode control
- `mem_reg_write`  in  1  MEM-stage write enable
- `mem_write_reg`  in  REG_ADDR_WIDTH  MEM-stage destination
- `mem_alu_result`  in  DATA_WIDTH  MEM-stage result
- `wb_reg_write`  in  1  WB-stage write enable
- `wb_write_reg`  in  REG_ADDR_WIDTH  WB-stage destination
- `wb_result`  in  DATA_WIDTH  WB-stage result
- `alu_a`, `alu_b`  out  DATA_WIDTH  ALU operands
- `alu_control`  out  4  registered ALU opcode
- `ex_write_data`  out  DATA_WIDTH  forwarded rt value (store data)
- `ex_write_reg`  out  REG_ADDR_WIDTH  selected destination
- `ex_reg_write`, `ex_mem_write`, `ex_mem_to_reg`, `ex_branch`  out  1 each  registered control
- `ex_valid`  out  1  stage holds a real instruction
- `forward_a`, `forward_b`  out  2  select taken: 00 reg, 10 MEM, 01 WB

## Operation
- Update priority on each edge: `reset` > `flush` > `stall` > load.
- Reset and flush clear every register to 0. This includes all control bits, `ex_valid`, indices, data and `alu_control` (4'b0000).
- Stall holds all registers unchanged.
- Load captures all `id_*` fields and sets `ex_valid`=1.
- `ex_write_reg` = registered `id_reg_dst ? id_rd : id_rt`. The selection is made at capture time.
- Forwarding (combinational, from registered rs/rt and live MEM/WB inputs):
  - Forward from MEM (10) when `mem_reg_write` && `mem_write_reg`≠0 && `mem_write_reg`==rs (or rt).
  - Otherwise forward from WB (01) under the same conditions using the `wb_*` inputs.
  - Otherwise use the registered read data (00).
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
- `ex_write_data` = forwarded rt value.
- `alu_a` = forwarded rs value.
- `alu_b` = registered `alu_src` ? registered imm : forwarded rt value.
- The block never modifies data widths; all paths are DATA_WIDTH wide with no extension.

## Timing
- One-cycle latency: `id_*` sampled at edge N appear on `ex_*`/`alu_*` after edge N.
- Forwarding paths are zero-cycle. A change on `mem_*`/`wb_*` reflects on `alu_a`/`alu_b` in the same cycle.
- `stall` and `flush` in the same cycle: flush wins and a bubble is loaded.
- Reset asserted mid-stream: outputs read 0 after the next edge regardless of stall or flush. `alu_a`=`alu_b`=0 unless WB/MEM match register 0, which is impossible.
- While stalled, forwarding continues to track live MEM/WB inputs.

## Configuration
- `KIM_ID_EX_FWD_EN` defined: forwarding logic as above.
- `KIM_ID_EX_FWD_EN` undefined:
  - `forward_a`/`forward_b` are tied to 00.
  - `alu_a`/`alu_b`/`ex_write_data` use only registered read data.
  - The hazard unit must stall on all RAW hazards.
  - Register/capture behaviour is unchanged.

## Test plan
- Reset: assert `reset` 2 cycles with nonzero `id_*` -> all outputs 0, `ex_valid`=0, `alu_control`=0000.
- Plain load, no hazard: `id_rd1`=5, `id_rd2`=7, `alu_src`=0, `alu_control`=0010 -> next cycle `alu_a`=5, `alu_b`=7, `forward_*`=00.
- Immediate path: `alu_src`=1, `id_imm`=0xFFFFFFFC -> `alu_b`=0xFFFFFFFC; `ex_write_data` still equals the rt value.
- Double hazard: rs=rt=3, MEM writes r3=0x11, WB writes r3=0x22 -> `alu_a`=`alu_b`=0x11, `forward`=10. Drop `mem_reg_write` -> both become 0x22, `forward`=01. Same setup with rs=0 -> `forward_a`=00.
- Stall/flush: `stall`=1 for 3 cycles with changing `id_*` -> outputs held. Then `stall`=`flush`=1 -> `ex_valid`=0, `ex_reg_write`=`ex_mem_write`=`ex_branch`=0.
- Macro off: the double-hazard scenario -> `alu_a` = registered `id_rd1`, `forward_*`=00.

Source files
------------

// File: rtl/kim_id_ex_p.sv
// kim_id_ex_p: ID/EX pipeline register with EX-stage operand forwarding from MEM/WB.
// Define KIM_ID_EX_FWD_EN to enable forwarding; otherwise operands come only from registered read data.
module kim_id_ex_p #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     id_rd1,
  input  logic [DATA_WIDTH-1:0]     id_rd2,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [3:0]                id_alu_control,
  input  logic                      id_alu_src,
  input  logic                      id_reg_dst,
  input  logic                      id_reg_write,
  input  logic                      id_mem_write,
  input  logic                      id_mem_to_reg,
  input  logic                      id_branch,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_reg,
  input  logic [DATA_WIDTH-1:0]     mem_alu_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_write_reg,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  output logic [3:0]                alu_control,
  output logic [DATA_WIDTH-1:0]     ex_write_data,
  output logic [REG_ADDR_WIDTH-1:0] ex_write_reg,
  output logic                      ex_reg_write,
  output logic                      ex_mem_write,
  output logic                      ex_mem_to_reg,
  output logic                      ex_branch,
  output logic                      ex_valid,
  output logic [1:0]                forward_a,
  output logic [1:0]                forward_b
);
`ifdef KIM_ID_EX_FWD_EN
  localparam bit fwd_en = 1'b1;
`else
  localparam bit fwd_en = 1'b0;
`endif
  logic [DATA_WIDTH-1:0]     rd1_q, rd2_q, imm_q, fwd_rs, fwd_rt;
  logic [REG_ADDR_WIDTH-1:0] rs_q, rt_q;
  logic                      alu_src_q, mem_a, wb_a, mem_b, wb_b;
  always_ff @(posedge clk)
    if (reset || flush) begin
      rd1_q         <= '0;
      rd2_q         <= '0;
      imm_q         <= '0;
      rs_q          <= '0;
      rt_q          <= '0;
      alu_src_q     <= 1'b0;
      alu_control   <= 4'b0000;
      ex_write_reg  <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_valid      <= 1'b0;
    end else if (!stall) begin
      rd1_q         <= id_rd1;
      rd2_q         <= id_rd2;
      imm_q         <= id_imm;
      rs_q          <= id_rs;
      rt_q          <= id_rt;
      alu_src_q     <= id_alu_src;
      alu_control   <= id_alu_control;
      ex_write_reg  <= id_reg_dst ? id_rd : id_rt;
      ex_reg_write  <= id_reg_write;
      ex_mem_write  <= id_mem_write;
      ex_mem_to_reg <= id_mem_to_reg;
      ex_branch     <= id_branch;
      ex_valid      <= 1'b1;
    end
  // r0 is hardwired zero, so a pending write to it must never be forwarded
  assign mem_a = fwd_en && mem_reg_write && mem_write_reg != '0 && mem_write_reg == rs_q;
  assign wb_a  = fwd_en && wb_reg_write  && wb_write_reg  != '0 && wb_write_reg  == rs_q;
  assign mem_b = fwd_en && mem_reg_write && mem_write_reg != '0 && mem_write_reg == rt_q;
  assign wb_b  = fwd_en && wb_reg_write  && wb_write_reg  != '0 && wb_write_reg  == rt_q;
  assign forward_a     = mem_a ? 2'b10 : wb_a ? 2'b01 : 2'b00;
  assign forward_b     = mem_b ? 2'b10 : wb_b ? 2'b01 : 2'b00;
  assign fwd_rs        = mem_a ? mem_alu_result : wb_a ? wb_result : rd1_q;
  assign fwd_rt        = mem_b ? mem_alu_result : wb_b ? wb_result : rd2_q;
  assign alu_a         = fwd_rs;
  assign ex_write_data = fwd_rt;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
endmodule

// File: tb/tb_kim_id_ex_p.sv
// tb_kim_id_ex_p: randomized scoreboard bench for the ID/EX register with forwarding.
module tb_kim_id_ex_p;
  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [3:0]  id_alu_control;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_write, id_mem_to_reg, id_branch;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_write_reg, wb_write_reg;
  logic [31:0] mem_alu_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_write_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch, ex_valid;
  logic [1:0]  forward_a, forward_b;
  typedef struct packed {
    logic        v, src, rw, mw, mtr, br;
    logic [4:0]  rs, rt, wreg;
    logic [3:0]  ctl;
    logic [31:0] rd1, rd2, imm;
  } st_t;
  typedef struct packed {
    logic [31:0] a, b, wd;
    logic [4:0]  wreg;
    logic [3:0]  ctl;
    logic        rw, mw, mtr, br, v;
    logic [1:0]  fa, fb;
  } exp_t;
  exp_t q[$];
  st_t  s;
  int   errors = 0, checks = 0;
  always #5 clk = ~clk;
  kim_id_ex_p dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .mem_reg_write(mem_reg_write), .mem_write_reg(mem_write_reg), .mem_alu_result(mem_alu_result),
    .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_write_data(ex_write_data), .ex_write_reg(ex_write_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_valid(ex_valid),
    .forward_a(forward_a), .forward_b(forward_b)
  );
  // which source supplies register r right now, given the live MEM/WB state
  function automatic logic [1:0] src_of(input logic [4:0] r);
`ifdef KIM_ID_EX_FWD_EN
    if (r != 0 && mem_reg_write && mem_write_reg == r) return 2'b10;
    if (r != 0 && wb_reg_write && wb_write_reg == r) return 2'b01;
`endif
    return 2'b00;
  endfunction
  function automatic logic [31:0] val_of(input logic [1:0] sel, input logic [31:0] regval);
    return sel == 2'b10 ? mem_alu_result : sel == 2'b01 ? wb_result : regval;
  endfunction
  task automatic tick();
    exp_t e;
    if (reset || flush) s = '0;
    else if (!stall) begin
      s.v = 1'b1; s.rs = id_rs; s.rt = id_rt; s.wreg = id_reg_dst ? id_rd : id_rt;
      s.rd1 = id_rd1; s.rd2 = id_rd2; s.imm = id_imm; s.src = id_alu_src; s.ctl = id_alu_control;
      s.rw = id_reg_write; s.mw = id_mem_write; s.mtr = id_mem_to_reg; s.br = id_branch;
    end
    e.fa = src_of(s.rs);
    e.fb = src_of(s.rt);
    e.a = val_of(e.fa, s.rd1);
    e.wd = val_of(e.fb, s.rd2);
    e.b = s.src ? s.imm : e.wd;
    e.wreg = s.wreg; e.ctl = s.ctl; e.rw = s.rw; e.mw = s.mw; e.mtr = s.mtr; e.br = s.br; e.v = s.v;
    q.push_back(e);
    @(negedge clk);
  endtask
  task automatic rand_id();
    id_rd1 = $urandom; id_rd2 = $urandom; id_imm = $urandom;
    id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3)); id_rd = 5'($urandom_range(0, 31));
    id_alu_control = 4'($urandom); {id_alu_src, id_reg_dst, id_reg_write, id_mem_write, id_mem_to_reg, id_branch} = 6'($urandom);
  endtask
  task automatic rand_fwd();
    mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
    mem_write_reg = 5'($urandom_range(0, 3)); wb_write_reg = 5'($urandom_range(0, 3));
    mem_alu_result = $urandom; wb_result = $urandom;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("ex_write_data", ex_write_data, e.wd);
        chk("ex_write_reg", 32'(ex_write_reg), 32'(e.wreg));
        chk("alu_control", 32'(alu_control), 32'(e.ctl));
        chk("ctrl", 32'({ex_reg_write, ex_mem_write, ex_mem_to_reg, ex_branch}), 32'({e.rw, e.mw, e.mtr, e.br}));
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("forward_a", 32'(forward_a), 32'(e.fa));
        chk("forward_b", 32'(forward_b), 32'(e.fb));
      end
    end
  end
  initial begin
    s = '0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_id(); rand_fwd();
    tick(); rand_id(); tick();
    reset = 1'b0; mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    id_rd1 = 32'd5; id_rd2 = 32'd7; id_alu_src = 1'b0; id_alu_control = 4'b0010; id_rs = 5'd1; id_rt = 5'd2;
    tick();
    id_alu_src = 1'b1; id_imm = 32'hFFFF_FFFC;
    tick();
    id_alu_src = 1'b0; id_rs = 5'd3; id_rt = 5'd3;
    mem_reg_write = 1'b1; mem_write_reg = 5'd3; mem_alu_result = 32'h11;
    wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_result = 32'h22;
    tick();
    stall = 1'b1; mem_reg_write = 1'b0;
    tick();
    stall = 1'b0; mem_reg_write = 1'b1; id_rs = 5'd0;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_id(); tick(); end
    flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rand_id(); rand_fwd();
      reset = ($urandom_range(0, 29) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    @(posedge clk);
    #2;
    chk("drain", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
